alarm_bank: RTL and testbench

ALARM_BANK -- requirements
Module: alarm_bank

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/alarm_channel.sv | 156 +++++++++++++++
 rtl/alarm_bank.sv | 147 ++++++++++++++
 tb/tb_alarm_bank.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm bank: channel state encoding,
// clock-face limits and the wrap-around increment used when editing settings.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } alarm_state_e;

    localparam logic [31:0] HOURS_PER_DAY = 32'd24;
    localparam logic [31:0] MIN_PER_HOUR  = 32'd60;

    // Increment with wrap to zero; any value at or above the last legal one
    // wraps so an out-of-range setting can never be produced.
    function automatic logic [31:0] wrap_inc(input logic [31:0] value,
                                             input logic [31:0] modulus);
        logic [31:0] result;
        if (value >= (modulus - 32'd1)) begin
            result = 32'd0;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: hour/minute setting, arm flag, and the
// IDLE / RINGING / SNOOZED state machine with its second and minute counters.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int TIME_W     = 14,
    parameter int RING_SECS  = 30,
    parameter int SNOOZE_MIN = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sec_tick,
    input  logic [TIME_W-1:0] hour,
    input  logic [TIME_W-1:0] minute,
    input  logic              time_changed,
    input  logic              minute_changed,
    input  logic              edit_sel,
    input  logic              setting_enable,
    input  logic              set_hr_or_min,
    input  logic              inc_pulse,
    input  logic              toggle_pulse,
    input  logic              snooze_pulse,
    input  logic              stop_pulse,
    output logic [TIME_W-1:0] set_hour,
    output logic [TIME_W-1:0] set_minute,
    output logic              armed,
    output logic              ringing
);

    localparam int RING_W   = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam int SNOOZE_W = (SNOOZE_MIN > 1) ? $clog2(SNOOZE_MIN) : 1;
    localparam logic [RING_W-1:0]   RING_LAST   = RING_W'(RING_SECS - 1);
    localparam logic [SNOOZE_W-1:0] SNOOZE_LAST = SNOOZE_W'(SNOOZE_MIN - 1);

    logic [TIME_W-1:0]   set_hour_r;
    logic [TIME_W-1:0]   set_minute_r;
    logic                armed_r;
    alarm_state_e        state_r;
    logic [RING_W-1:0]   ring_cnt_r;
    logic [SNOOZE_W-1:0] snooze_cnt_r;
    logic                ringing_r;
    logic                trigger_s;
    logic                disarm_s;

    // Trigger only on the cycle the wall time moves onto the setting; disarm
    // is an enable-toggle edge that hits a currently armed channel.
    always_comb begin
        trigger_s = 1'b0;
        if (armed_r && !setting_enable && time_changed &&
            (hour == set_hour_r) && (minute == set_minute_r)) begin
            trigger_s = 1'b1;
        end else begin
            trigger_s = 1'b0;
        end
        disarm_s = edit_sel & toggle_pulse & armed_r;
    end

    // Setting registers and arm flag, changed only while this channel is selected
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            set_hour_r   <= {TIME_W{1'b0}};
            set_minute_r <= {TIME_W{1'b0}};
            armed_r      <= 1'b0;
        end else begin
            if (edit_sel && inc_pulse) begin
                if (set_hr_or_min) begin
                    set_minute_r <= TIME_W'(wrap_inc(32'(set_minute_r), MIN_PER_HOUR));
                end else begin
                    set_hour_r <= TIME_W'(wrap_inc(32'(set_hour_r), HOURS_PER_DAY));
                end
            end
            if (edit_sel && toggle_pulse) begin
                armed_r <= ~armed_r;
            end
        end
    end

    // Channel state machine; stop outranks snooze and trigger, disarm outranks all
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ring_cnt_r   <= {RING_W{1'b0}};
            snooze_cnt_r <= {SNOOZE_W{1'b0}};
            ringing_r    <= 1'b0;
        end else if (disarm_s) begin
            state_r      <= ST_IDLE;
            ring_cnt_r   <= {RING_W{1'b0}};
            snooze_cnt_r <= {SNOOZE_W{1'b0}};
            ringing_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (trigger_s && !stop_pulse) begin
                        state_r    <= ST_RINGING;
                        ring_cnt_r <= {RING_W{1'b0}};
                        ringing_r  <= 1'b1;
                    end else begin
                        ringing_r  <= 1'b0;
                    end
                end
                ST_RINGING: begin
                    if (stop_pulse) begin
                        state_r    <= ST_IDLE;
                        ring_cnt_r <= {RING_W{1'b0}};
                        ringing_r  <= 1'b0;
                    end else if (snooze_pulse) begin
                        state_r      <= ST_SNOOZED;
                        ring_cnt_r   <= {RING_W{1'b0}};
                        snooze_cnt_r <= {SNOOZE_W{1'b0}};
                        ringing_r    <= 1'b0;
                    end else if (sec_tick) begin
                        if (ring_cnt_r == RING_LAST) begin
                            state_r    <= ST_IDLE;
                            ring_cnt_r <= {RING_W{1'b0}};
                            ringing_r  <= 1'b0;
                        end else begin
                            ring_cnt_r <= ring_cnt_r + RING_W'(1);
                        end
                    end else begin
                        ringing_r <= 1'b1;
                    end
                end
                ST_SNOOZED: begin
                    if (stop_pulse) begin
                        state_r      <= ST_IDLE;
                        snooze_cnt_r <= {SNOOZE_W{1'b0}};
                        ringing_r    <= 1'b0;
                    end else if (minute_changed) begin
                        if (snooze_cnt_r == SNOOZE_LAST) begin
                            state_r      <= ST_RINGING;
                            snooze_cnt_r <= {SNOOZE_W{1'b0}};
                            ring_cnt_r   <= {RING_W{1'b0}};
                            ringing_r    <= 1'b1;
                        end else begin
                            snooze_cnt_r <= snooze_cnt_r + SNOOZE_W'(1);
                        end
                    end else begin
                        ringing_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    ring_cnt_r   <= {RING_W{1'b0}};
                    snooze_cnt_r <= {SNOOZE_W{1'b0}};
                    ringing_r    <= 1'b0;
                end
            endcase
        end
    end

    assign set_hour   = set_hour_r;
    assign set_minute = set_minute_r;
    assign armed      = armed_r;
    assign ringing    = ringing_r;

endmodule

// File: rtl/alarm_bank.sv
// Bank of independent alarm channels sharing one wall clock and one set of
// buttons. Buttons are edge-detected here and fanned out as one-cycle pulses.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int TIME_W     = 14,
    parameter int RING_SECS  = 30,
    parameter int SNOOZE_MIN = 5,
    localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sec_tick,
    input  logic [TIME_W-1:0]     hour,
    input  logic [TIME_W-1:0]     minute,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  setting_enable,
    input  logic                  set_hr_or_min,
    input  logic                  inc_short,
    input  logic                  en_toggle,
    input  logic                  snooze,
    input  logic                  stop,
    output logic                  beep_out,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic [NUM_ALARMS-1:0] armed,
    output logic [TIME_W-1:0]     hour_out,
    output logic [TIME_W-1:0]     minute_out
);

    logic                  inc_prev_r;
    logic                  toggle_prev_r;
    logic                  snooze_prev_r;
    logic                  stop_prev_r;
    logic [TIME_W-1:0]     hour_prev_r;
    logic [TIME_W-1:0]     minute_prev_r;
    logic                  beep_r;
    logic [TIME_W-1:0]     hour_out_r;
    logic [TIME_W-1:0]     minute_out_r;

    logic                  inc_pulse_s;
    logic                  toggle_pulse_s;
    logic                  snooze_pulse_s;
    logic                  stop_pulse_s;
    logic                  time_changed_s;
    logic                  minute_changed_s;
    logic [NUM_ALARMS-1:0] edit_sel_s;
    logic [NUM_ALARMS-1:0] ringing_s;
    logic [NUM_ALARMS-1:0] armed_s;
    logic [TIME_W-1:0]     ch_hour_s   [NUM_ALARMS];
    logic [TIME_W-1:0]     ch_minute_s [NUM_ALARMS];
    logic [TIME_W-1:0]     sel_hour_s;
    logic [TIME_W-1:0]     sel_minute_s;

    // Button and wall-time history for edge and change detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inc_prev_r    <= 1'b0;
            toggle_prev_r <= 1'b0;
            snooze_prev_r <= 1'b0;
            stop_prev_r   <= 1'b0;
            hour_prev_r   <= {TIME_W{1'b0}};
            minute_prev_r <= {TIME_W{1'b0}};
        end else begin
            inc_prev_r    <= inc_short;
            toggle_prev_r <= en_toggle;
            snooze_prev_r <= snooze;
            stop_prev_r   <= stop;
            hour_prev_r   <= hour;
            minute_prev_r <= minute;
        end
    end

    // Rising-edge pulses, time-change flags and per-channel edit select
    always_comb begin
        inc_pulse_s      = inc_short & ~inc_prev_r;
        toggle_pulse_s   = en_toggle & ~toggle_prev_r;
        snooze_pulse_s   = snooze & ~snooze_prev_r;
        stop_pulse_s     = stop & ~stop_prev_r;
        minute_changed_s = (minute != minute_prev_r);
        time_changed_s   = (hour != hour_prev_r) | minute_changed_s;
        edit_sel_s       = {NUM_ALARMS{1'b0}};
        for (int i = 0; i < NUM_ALARMS; i++) begin
            edit_sel_s[i] = setting_enable & (sel == SEL_W'(i));
        end
    end

    // Read-back mux of the selected channel's setting; unused codes read zero
    always_comb begin
        sel_hour_s   = {TIME_W{1'b0}};
        sel_minute_s = {TIME_W{1'b0}};
        if (int'(sel) < NUM_ALARMS) begin
            sel_hour_s   = ch_hour_s[sel];
            sel_minute_s = ch_minute_s[sel];
        end else begin
            sel_hour_s   = {TIME_W{1'b0}};
            sel_minute_s = {TIME_W{1'b0}};
        end
    end

    // Registered read-back and beep, one cycle behind the channel registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hour_out_r   <= {TIME_W{1'b0}};
            minute_out_r <= {TIME_W{1'b0}};
            beep_r       <= 1'b0;
        end else begin
            hour_out_r   <= sel_hour_s;
            minute_out_r <= sel_minute_s;
            beep_r       <= |ringing_s;
        end
    end

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        alarm_channel #(
            .TIME_W    (TIME_W),
            .RING_SECS (RING_SECS),
            .SNOOZE_MIN(SNOOZE_MIN)
        ) u_channel (
            .clk           (clk),
            .rst_n         (rst_n),
            .sec_tick      (sec_tick),
            .hour          (hour),
            .minute        (minute),
            .time_changed  (time_changed_s),
            .minute_changed(minute_changed_s),
            .edit_sel      (edit_sel_s[g]),
            .setting_enable(setting_enable),
            .set_hr_or_min (set_hr_or_min),
            .inc_pulse     (inc_pulse_s),
            .toggle_pulse  (toggle_pulse_s),
            .snooze_pulse  (snooze_pulse_s),
            .stop_pulse    (stop_pulse_s),
            .set_hour      (ch_hour_s[g]),
            .set_minute    (ch_minute_s[g]),
            .armed         (armed_s[g]),
            .ringing       (ringing_s[g])
        );
    end

    assign beep_out   = beep_r;
    assign ringing    = ringing_s;
    assign armed      = armed_s;
    assign hour_out   = hour_out_r;
    assign minute_out = minute_out_r;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed scenarios followed by a random phase, all checked every cycle
// against a behavioural model that tracks seconds/minutes left per channel.
module tb_alarm_bank;

    localparam int N  = 4;
    localparam int TW = 14;
    localparam int RS = 30;
    localparam int SM = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sec_tick;
    logic [TW-1:0] hour;
    logic [TW-1:0] minute;
    logic [1:0]    sel;
    logic          setting_enable;
    logic          set_hr_or_min;
    logic          inc_short;
    logic          en_toggle;
    logic          snooze;
    logic          stop;
    logic          beep_out;
    logic [N-1:0]  ringing;
    logic [N-1:0]  armed;
    logic [TW-1:0] hour_out;
    logic [TW-1:0] minute_out;

    always #5 clk = ~clk;

    alarm_bank #(
        .NUM_ALARMS(N),
        .TIME_W    (TW),
        .RING_SECS (RS),
        .SNOOZE_MIN(SM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sec_tick      (sec_tick),
        .hour          (hour),
        .minute        (minute),
        .sel           (sel),
        .setting_enable(setting_enable),
        .set_hr_or_min (set_hr_or_min),
        .inc_short     (inc_short),
        .en_toggle     (en_toggle),
        .snooze        (snooze),
        .stop          (stop),
        .beep_out      (beep_out),
        .ringing       (ringing),
        .armed         (armed),
        .hour_out      (hour_out),
        .minute_out    (minute_out)
    );

    int errors = 0;
    int checks = 0;
    string phase = "init";

    // Reference model: settings, arm flags, and time left in ringing/snooze
    int m_h[N];
    int m_m[N];
    bit m_arm[N];
    int ring_left[N];
    int snooze_left[N];
    bit p_inc, p_tog, p_snz, p_stop;
    int p_hour, p_min;
    logic [N-1:0]  exp_ringing;
    logic [N-1:0]  exp_armed;
    logic          exp_beep;
    logic [31:0]   exp_hout;
    logic [31:0]   exp_mout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ie, te, se, pe, tchg, mchg, hit;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_h[i] = 0; m_m[i] = 0; m_arm[i] = 0;
                ring_left[i] = 0; snooze_left[i] = 0;
            end
            exp_beep = 1'b0; exp_hout = 32'd0; exp_mout = 32'd0;
            p_inc = 0; p_tog = 0; p_snz = 0; p_stop = 0; p_hour = 0; p_min = 0;
        end else begin
            exp_beep = 1'b0;
            for (int i = 0; i < N; i++) if (ring_left[i] > 0) exp_beep = 1'b1;
            exp_hout = 32'(m_h[sel]);
            exp_mout = 32'(m_m[sel]);
            ie = inc_short && !p_inc;
            te = en_toggle && !p_tog;
            se = snooze && !p_snz;
            pe = stop && !p_stop;
            mchg = (int'(minute) != p_min);
            tchg = mchg || (int'(hour) != p_hour);
            for (int i = 0; i < N; i++) begin
                hit = setting_enable && (int'(sel) == i);
                if (hit && te && m_arm[i]) begin
                    ring_left[i] = 0; snooze_left[i] = 0;
                end else if (ring_left[i] > 0) begin
                    if (pe) ring_left[i] = 0;
                    else if (se) begin ring_left[i] = 0; snooze_left[i] = SM; end
                    else if (sec_tick) ring_left[i]--;
                end else if (snooze_left[i] > 0) begin
                    if (pe) snooze_left[i] = 0;
                    else if (mchg) begin
                        snooze_left[i]--;
                        if (snooze_left[i] == 0) ring_left[i] = RS;
                    end
                end else if (!pe && m_arm[i] && !setting_enable && tchg &&
                             int'(hour) == m_h[i] && int'(minute) == m_m[i]) begin
                    ring_left[i] = RS;
                end
                if (hit && te) m_arm[i] = !m_arm[i];
                if (hit && ie) begin
                    if (set_hr_or_min) m_m[i] = (m_m[i] + 1) % 60;
                    else m_h[i] = (m_h[i] + 1) % 24;
                end
            end
            p_inc = inc_short; p_tog = en_toggle; p_snz = snooze; p_stop = stop;
            p_hour = int'(hour); p_min = int'(minute);
        end
        for (int i = 0; i < N; i++) begin
            exp_ringing[i] = (ring_left[i] > 0);
            exp_armed[i]   = m_arm[i];
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("ringing", 32'(ringing), 32'(exp_ringing));
        check("armed", 32'(armed), 32'(exp_armed));
        check("beep_out", 32'(beep_out), 32'(exp_beep));
        check("hour_out", 32'(hour_out), exp_hout);
        check("minute_out", 32'(minute_out), exp_mout);
    endtask

    task automatic pulse(input bit i_inc, input bit i_tog, input bit i_snz, input bit i_stop);
        inc_short = i_inc; en_toggle = i_tog; snooze = i_snz; stop = i_stop;
        step();
        inc_short = 0; en_toggle = 0; snooze = 0; stop = 0;
        step();
    endtask

    task automatic set_channel(input int ch, input int h, input int m);
        int n;
        setting_enable = 1; sel = 2'(ch); set_hr_or_min = 0;
        n = (h - m_h[ch] + 24) % 24;
        repeat (n) pulse(1, 0, 0, 0);
        set_hr_or_min = 1;
        n = (m - m_m[ch] + 60) % 60;
        repeat (n) pulse(1, 0, 0, 0);
        setting_enable = 0;
        step();
    endtask

    task automatic arm(input int ch);
        setting_enable = 1; sel = 2'(ch);
        pulse(0, 1, 0, 0);
        setting_enable = 0;
    endtask

    task automatic set_time(input int h, input int m);
        hour = TW'(h); minute = TW'(m);
        step();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            sec_tick = 1; step();
            sec_tick = 0; step();
        end
    endtask

    initial begin
        rst_n = 0; sec_tick = 0; hour = '0; minute = '0; sel = 2'd0;
        setting_enable = 0; set_hr_or_min = 0;
        inc_short = 0; en_toggle = 0; snooze = 0; stop = 0;

        phase = "reset";
        step(); step();
        check("rst_ringing", 32'(ringing), 32'd0);
        check("rst_beep", 32'(beep_out), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        rst_n = 1;
        step();

        phase = "wrap";
        set_channel(0, 23, 0);
        check("hour23", 32'(hour_out), 32'd23);
        setting_enable = 1; set_hr_or_min = 0;
        pulse(1, 0, 0, 0);
        check("hour_wrap", 32'(hour_out), 32'd0);
        setting_enable = 0;
        set_channel(0, 0, 59);
        check("min59", 32'(minute_out), 32'd59);
        setting_enable = 1; set_hr_or_min = 1;
        pulse(1, 0, 0, 0);
        check("min_wrap", 32'(minute_out), 32'd0);
        set_hr_or_min = 0; inc_short = 1;
        repeat (6) step();
        inc_short = 0; step();
        check("held_inc", 32'(hour_out), 32'd1);
        setting_enable = 0;

        phase = "ring0730";
        set_channel(1, 7, 30);
        arm(1);
        set_time(7, 29);
        set_time(7, 30);
        check("ring_start", 32'(ringing), 32'b0010);
        check("beep_lag", 32'(beep_out), 32'd0);
        step();
        check("beep_on", 32'(beep_out), 32'd1);
        ticks(29);
        check("ring_29", 32'(ringing), 32'b0010);
        ticks(1);
        check("ring_30", 32'(ringing), 32'd0);

        phase = "snooze";
        set_time(7, 31);
        set_time(7, 30);
        check("retrig", 32'(ringing), 32'b0010);
        pulse(0, 0, 1, 0);
        check("snoozed", 32'(ringing), 32'd0);
        for (int k = 1; k <= 4; k++) set_time(7, 30 + k);
        check("snooze_4", 32'(ringing), 32'd0);
        set_time(7, 35);
        check("snooze_5", 32'(ringing), 32'b0010);
        pulse(0, 0, 1, 1);
        check("stop_snz", 32'(ringing), 32'd0);
        for (int k = 36; k <= 43; k++) set_time(7, k);
        check("no_rering", 32'(ringing), 32'd0);

        phase = "multi";
        set_channel(0, 6, 0);
        set_channel(2, 6, 0);
        arm(0); arm(2);
        set_time(5, 59);
        set_time(6, 0);
        check("both_ring", 32'(ringing), 32'b0101);
        pulse(0, 0, 0, 1);
        check("both_stop", 32'(ringing), 32'd0);

        phase = "hold";
        ticks(60);
        check("held_match", 32'(ringing), 32'd0);
        set_channel(3, 6, 5);
        set_time(6, 5);
        check("unarmed", 32'(ringing), 32'd0);
        check("arm_map", 32'(armed), 32'b0111);

        phase = "reset_ring";
        set_time(6, 1);
        set_time(6, 0);
        check("pre_rst", 32'(ringing), 32'b0101);
        step();
        rst_n = 0; step();
        check("rst_ring", 32'(ringing), 32'd0);
        check("rst_beep2", 32'(beep_out), 32'd0);
        check("rst_hout", 32'(hour_out), 32'd0);
        rst_n = 1;
        ticks(5);
        set_time(6, 1);
        set_time(6, 0);
        step();
        check("post_rst_beep", 32'(beep_out), 32'd0);

        phase = "random";
        for (int k = 0; k < 3000; k++) begin
            rst_n          = ($urandom_range(0, 499) != 0);
            sel            = 2'($urandom_range(0, 3));
            setting_enable = ($urandom_range(0, 3) == 0);
            set_hr_or_min  = 1'($urandom_range(0, 1));
            inc_short      = ($urandom_range(0, 5) == 0);
            en_toggle      = ($urandom_range(0, 4) == 0);
            snooze         = ($urandom_range(0, 9) == 0);
            stop           = ($urandom_range(0, 19) == 0);
            sec_tick       = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 2) == 0) begin
                hour   = TW'($urandom_range(0, 1));
                minute = TW'($urandom_range(0, 2));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
